fc_sgd_sequencer: RTL

Sequencer for one SGD training step of the final fully connected layer (196 inputs, 10 outputs, Q8.8). After a `start` pulse it walks every output neuron and then every input. It reads the forward output, label, FC input, bias and weight from single-port synchronous buffers through one shared multiplier path, and writes back the updated bias and weight in place. It sits between the forward FC engine's buffers and the training controller, and replaces fully parallel update generation with a serialized read-modify-write schedule.

---
 rtl/fc_sgd_sequencer_if.sv | 47 ++++
 rtl/fc_sgd_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fc_sgd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fc_sgd_sequencer_if
// Description : Handshake and buffer-port bundle between the SGD update
//               sequencer and the FC output/label/input/bias/weight buffers.
// Revision    : 1.0 - initial release
// ============================================================================
interface fc_sgd_sequencer_if #(
    parameter int N_OUT = 10,
    parameter int N_IN  = 196,
    parameter int DW    = 16
) ();
    localparam int OAW = $clog2(N_OUT);
    localparam int IAW = $clog2(N_IN);
    localparam int WAW = $clog2(N_OUT * N_IN);

    logic           start;
    logic [DW-1:0]  lr;
    logic           busy;
    logic           done;
    logic [OAW-1:0] out_addr;
    logic [DW-1:0]  out_data;
    logic [DW-1:0]  lbl_data;
    logic [IAW-1:0] in_addr;
    logic [DW-1:0]  in_data;
    logic [OAW-1:0] b_addr;
    logic [DW-1:0]  b_rdata;
    logic           b_we;
    logic [DW-1:0]  b_wdata;
    logic [WAW-1:0] w_addr;
    logic [DW-1:0]  w_rdata;
    logic           w_we;
    logic [DW-1:0]  w_wdata;

    modport master (
        input  start, lr, out_data, lbl_data, in_data, b_rdata, w_rdata,
        output busy, done, out_addr, in_addr, b_addr, b_we, b_wdata,
               w_addr, w_we, w_wdata
    );

    modport slave (
        output start, lr, out_data, lbl_data, in_data, b_rdata, w_rdata,
        input  busy, done, out_addr, in_addr, b_addr, b_we, b_wdata,
               w_addr, w_we, w_wdata
    );
endinterface
`default_nettype wire

// File: rtl/fc_sgd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fc_sgd_sequencer
// Description : Serialized read-modify-write SGD step for the final FC layer:
//               bias and weight updates through one shared multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_sgd_sequencer #(
    parameter int N_OUT = 10,
    parameter int N_IN  = 196,
    parameter int DW    = 16,
    parameter int FRAC  = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fc_sgd_sequencer_if.master  bus
);
    localparam int OAW = $clog2(N_OUT);
    localparam int IAW = $clog2(N_IN);
    localparam int WAW = $clog2(N_OUT * N_IN);
    localparam int PW  = 2 * DW;

    localparam logic [OAW-1:0]        c_I_LAST  = OAW'(N_OUT - 1);
    localparam logic [IAW-1:0]        c_J_LAST  = IAW'(N_IN - 1);
    localparam logic signed [PW-1:0]  c_SAT_MAX = PW'((1 << (DW - 1)) - 1);
    localparam logic signed [PW-1:0]  c_SAT_MIN = -c_SAT_MAX - PW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERR_REQ = 3'd1,
        S_ERR_LAT = 3'd2,
        S_BIAS_WR = 3'd3,
        S_W_REQ   = 3'd4,
        S_W_LAT   = 3'd5,
        S_W_WR    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    function automatic logic signed [PW-1:0] sext(input logic [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [PW-1:0] v);
        if (v > c_SAT_MAX)
            return c_SAT_MAX[DW-1:0];
        else if (v < c_SAT_MIN)
            return c_SAT_MIN[DW-1:0];
        else
            return v[DW-1:0];
    endfunction

    state_t          r_state;
    logic [OAW-1:0]  r_i;
    logic [IAW-1:0]  r_j;
    logic [DW-1:0]   r_lr;
    logic [DW-1:0]   r_delta;
    logic            r_busy;
    logic            r_done;
    logic [OAW-1:0]  r_out_addr;
    logic [IAW-1:0]  r_in_addr;
    logic [OAW-1:0]  r_b_addr;
    logic [WAW-1:0]  r_w_addr;
    logic            r_b_we;
    logic            r_w_we;
    logic [DW-1:0]   r_b_wdata;
    logic [DW-1:0]   r_w_wdata;

    logic [DW-1:0]        w_diff;
    logic [DW-1:0]        w_mul_a;
    logic [DW-1:0]        w_mul_b;
    logic signed [PW-1:0] w_prod;
    logic [DW-1:0]        w_scaled;
    logic [DW-1:0]        w_bias_new;
    logic [DW-1:0]        w_wt_new;

    // The multiplier is shared: lr*diff while the error word is on the bus,
    // delta*x while a weight/input pair is on the bus.
    assign w_diff     = sat(sext(bus.out_data) - sext(bus.lbl_data));
    assign w_mul_a    = (r_state == S_ERR_LAT) ? r_lr   : r_delta;
    assign w_mul_b    = (r_state == S_ERR_LAT) ? w_diff : bus.in_data;
    assign w_prod     = sext(w_mul_a) * sext(w_mul_b);
    assign w_scaled   = sat(w_prod >>> FRAC);
    assign w_bias_new = sat(sext(bus.b_rdata) - sext(w_scaled));
    assign w_wt_new   = sat(sext(bus.w_rdata) - sext(w_scaled));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_lr       <= '0;
            r_delta    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_out_addr <= '0;
            r_in_addr  <= '0;
            r_b_addr   <= '0;
            r_w_addr   <= '0;
            r_b_we     <= 1'b0;
            r_w_we     <= 1'b0;
            r_b_wdata  <= '0;
            r_w_wdata  <= '0;
        end else begin
            r_b_we <= 1'b0;
            r_w_we <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_lr       <= bus.lr;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_busy     <= 1'b1;
                        r_out_addr <= '0;
                        r_b_addr   <= '0;
                        r_in_addr  <= '0;
                        r_w_addr   <= '0;
                        r_state    <= S_ERR_REQ;
                    end
                end
                S_ERR_REQ: r_state <= S_ERR_LAT;
                S_ERR_LAT: begin
                    r_delta   <= w_scaled;
                    r_b_wdata <= w_bias_new;
                    r_b_we    <= 1'b1;
                    r_state   <= S_BIAS_WR;
                end
                // w_addr already holds i*N_IN here thanks to the running count
                S_BIAS_WR: begin
                    r_in_addr <= r_j;
                    r_state   <= S_W_REQ;
                end
                S_W_REQ: r_state <= S_W_LAT;
                S_W_LAT: begin
                    r_w_wdata <= w_wt_new;
                    r_w_we    <= 1'b1;
                    r_state   <= S_W_WR;
                end
                S_W_WR: begin
                    if (r_j != c_J_LAST) begin
                        r_j       <= r_j + 1'b1;
                        r_in_addr <= r_j + 1'b1;
                        r_w_addr  <= r_w_addr + 1'b1;
                        r_state   <= S_W_REQ;
                    end else if (r_i != c_I_LAST) begin
                        r_j        <= '0;
                        r_i        <= r_i + 1'b1;
                        r_out_addr <= r_i + 1'b1;
                        r_b_addr   <= r_i + 1'b1;
                        r_w_addr   <= r_w_addr + 1'b1;
                        r_state    <= S_ERR_REQ;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.out_addr = r_out_addr;
    assign bus.in_addr  = r_in_addr;
    assign bus.b_addr   = r_b_addr;
    assign bus.b_we     = r_b_we;
    assign bus.b_wdata  = r_b_wdata;
    assign bus.w_addr   = r_w_addr;
    assign bus.w_we     = r_w_we;
    assign bus.w_wdata  = r_w_wdata;
endmodule
`default_nettype wire
